// File: rtl/equiv_mismatch_monitor.sv
// Compares two design-copy outputs sample by sample, counts compares/mismatches and
// holds one mismatch report behind a valid/ready handshake. Optional: EQUIV_MON_STAMP_EN.
module equiv_mismatch_monitor #(
   parameter int DATA_W = 91,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] y_1,
   input  logic [DATA_W-1:0] y_2,
   output logic              rpt_valid,
   input  logic              rpt_ready,
   output logic [DATA_W-1:0] rpt_y1,
   output logic [DATA_W-1:0] rpt_y2,
   output logic [DATA_W-1:0] rpt_diff,
   output logic [CNT_W-1:0]  rpt_stamp,
   output logic [CNT_W-1:0]  cmp_count,
   output logic [CNT_W-1:0]  mis_count,
   output logic              busy,
   output logic              fail,
   output logic              dropped
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cmp_count_reg, mis_count_reg;
   logic                rpt_valid_reg, dropped_reg;
   logic [DATA_W-1:0]   rpt_y1_reg, rpt_y2_reg, rpt_diff_reg;
   logic                accept, mismatch, load;

   // The start cycle belongs to the new run's setup, so its sample is never counted.
   assign accept   = (state_reg == RUN) && in_valid && !start;
   assign mismatch = accept && (y_1 != y_2);
   assign load     = mismatch && (!rpt_valid_reg || rpt_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, DONE: if (start) state_next = RUN;
         RUN: begin
            if (start)     state_next = RUN;
            else if (stop) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_count_reg <= '0;
         mis_count_reg <= '0;
         rpt_valid_reg <= 1'b0;
         dropped_reg   <= 1'b0;
         rpt_y1_reg    <= '0;
         rpt_y2_reg    <= '0;
         rpt_diff_reg  <= '0;
      end else if (start) begin
         cmp_count_reg <= '0;
         mis_count_reg <= '0;
         rpt_valid_reg <= 1'b0;
         dropped_reg   <= 1'b0;
      end else begin
         if (accept && cmp_count_reg != '1)   cmp_count_reg <= cmp_count_reg + CNT_ONE;
         if (mismatch && mis_count_reg != '1) mis_count_reg <= mis_count_reg + CNT_ONE;
         if (load) begin
            rpt_valid_reg <= 1'b1;
            rpt_y1_reg    <= y_1;
            rpt_y2_reg    <= y_2;
            rpt_diff_reg  <= y_1 ^ y_2;
         end else begin
            // A mismatch that cannot be loaded leaves the held report untouched.
            if (mismatch)                   dropped_reg   <= 1'b1;
            if (rpt_valid_reg && rpt_ready) rpt_valid_reg <= 1'b0;
         end
      end
   end

`ifdef EQUIV_MON_STAMP_EN
   logic [CNT_W-1:0] stamp_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                stamp_reg <= '0;
      else if (!start && load)   stamp_reg <= cmp_count_reg;
   end

   assign rpt_stamp = stamp_reg;
`else
   assign rpt_stamp = '0;
`endif

   assign rpt_valid = rpt_valid_reg;
   assign rpt_y1    = rpt_y1_reg;
   assign rpt_y2    = rpt_y2_reg;
   assign rpt_diff  = rpt_diff_reg;
   assign cmp_count = cmp_count_reg;
   assign mis_count = mis_count_reg;
   assign dropped   = dropped_reg;
   assign busy      = (state_reg == RUN);
   assign fail      = (mis_count_reg != '0);

endmodule

// File: tb/tb_equiv_mismatch_monitor.sv
// Scoreboard bench for equiv_mismatch_monitor: directed runs push expected reports,
// a monitor pops them on each report handshake; a CNT_W=4 copy checks saturation.
module tb_equiv_mismatch_monitor;

   localparam int DW = 91;
   localparam int CW = 16;

   typedef struct packed {
      logic [DW-1:0] y1;
      logic [DW-1:0] y2;
      logic [DW-1:0] diff;
      logic [CW-1:0] stamp;
   } rpt_t;

   logic          clk = 1'b0;
   logic          rst_n, start, stop, in_valid, rpt_ready;
   logic [DW-1:0] y_1, y_2;
   logic          rpt_valid, busy, fail, dropped;
   logic [DW-1:0] rpt_y1, rpt_y2, rpt_diff;
   logic [CW-1:0] rpt_stamp, cmp_count, mis_count;

   logic          s_start, s_stop, s_in_valid;
   logic [7:0]    s_y_1, s_y_2, s_rpt_y1, s_rpt_y2, s_rpt_diff;
   logic          s_rpt_valid, s_busy, s_fail, s_dropped;
   logic [3:0]    s_rpt_stamp, s_cmp_count, s_mis_count;

   int   errors = 0;
   int   checks = 0;
   int   reports = 0;
   bit   seen_valid = 1'b0;
   rpt_t exp_q[$];

   always #5 clk = ~clk;

   equiv_mismatch_monitor #(.DATA_W(DW), .CNT_W(CW)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
      .y_1(y_1), .y_2(y_2), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
      .rpt_y1(rpt_y1), .rpt_y2(rpt_y2), .rpt_diff(rpt_diff), .rpt_stamp(rpt_stamp),
      .cmp_count(cmp_count), .mis_count(mis_count), .busy(busy), .fail(fail),
      .dropped(dropped)
   );

   equiv_mismatch_monitor #(.DATA_W(8), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(s_start), .stop(s_stop), .in_valid(s_in_valid),
      .y_1(s_y_1), .y_2(s_y_2), .rpt_valid(s_rpt_valid), .rpt_ready(1'b1),
      .rpt_y1(s_rpt_y1), .rpt_y2(s_rpt_y2), .rpt_diff(s_rpt_diff), .rpt_stamp(s_rpt_stamp),
      .cmp_count(s_cmp_count), .mis_count(s_mis_count), .busy(s_busy), .fail(s_fail),
      .dropped(s_dropped)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   function automatic logic [CW-1:0] stp(input int k);
`ifdef EQUIV_MON_STAMP_EN
      return CW'(k);
`else
      return CW'(k - k);
`endif
   endfunction

   task automatic push_exp(input int a, input int b, input int d, input int k);
      rpt_t e;
      e.y1    = DW'(a);
      e.y2    = DW'(b);
      e.diff  = DW'(d);
      e.stamp = stp(k);
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic sample(input int a, input int b);
      in_valid = 1'b1;
      y_1 = DW'(a);
      y_2 = DW'(b);
      cyc();
      in_valid = 1'b0;
   endtask

   // Monitor: a handshake seen at the falling edge completes on the next rising edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rpt_valid) seen_valid = 1'b1;
         if (rst_n && rpt_valid && rpt_ready) begin
            reports++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_report: got y1=0x%0h y2=0x%0h expected none", rpt_y1, rpt_y2);
            end else begin
               rpt_t e;
               e = exp_q.pop_front();
               chk("rpt_y1", 128'(rpt_y1), 128'(e.y1));
               chk("rpt_y2", 128'(rpt_y2), 128'(e.y2));
               chk("rpt_diff", 128'(rpt_diff), 128'(e.diff));
               chk("rpt_stamp", 128'(rpt_stamp), 128'(e.stamp));
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; rpt_ready = 1'b0;
      y_1 = '0; y_2 = '0;
      s_start = 1'b0; s_stop = 1'b0; s_in_valid = 1'b0; s_y_1 = '0; s_y_2 = '0;
      cyc(); cyc();
      chk("reset_busy", 128'(busy), 128'(0));
      chk("reset_cmp", 128'(cmp_count), 128'(0));
      chk("reset_rpt_valid", 128'(rpt_valid), 128'(0));
      rst_n = 1'b1;
      cyc();

      // Ten equal samples: no report, counters 10/0, then DONE freezes counters.
      seen_valid = 1'b0;
      do_start();
      chk("run_busy", 128'(busy), 128'(1));
      for (int i = 0; i < 10; i++) sample(i * 7 + 1, i * 7 + 1);
      stop = 1'b1; cyc(); stop = 1'b0;
      chk("eq_cmp", 128'(cmp_count), 128'(10));
      chk("eq_mis", 128'(mis_count), 128'(0));
      chk("eq_fail", 128'(fail), 128'(0));
      chk("eq_busy_done", 128'(busy), 128'(0));
      sample(3, 4);
      chk("done_cmp_frozen", 128'(cmp_count), 128'(10));
      chk("done_mis_frozen", 128'(mis_count), 128'(0));
      chk("eq_no_valid", 128'(seen_valid), 128'(0));

      // Samples 0..4, sample 3 mismatches (1 vs 3), consumer always ready.
      rpt_ready = 1'b1;
      do_start();
      for (int i = 0; i < 5; i++) begin
         if (i == 3) begin
            push_exp(1, 3, 2, 3);
            sample(1, 3);
            chk("lat1_valid", 128'(rpt_valid), 128'(1));
         end else begin
            sample(i + 20, i + 20);
         end
      end
      chk("one_mis_valid_cleared", 128'(rpt_valid), 128'(0));
      chk("one_mis_cmp", 128'(cmp_count), 128'(5));
      chk("one_mis_mis", 128'(mis_count), 128'(1));
      chk("one_mis_fail", 128'(fail), 128'(1));

      // Consumer stalled: second mismatch is dropped, first report kept.
      rpt_ready = 1'b0;
      do_start();
      chk("restart_mis", 128'(mis_count), 128'(0));
      sample(9, 9);
      push_exp(5, 4, 1, 1);
      sample(5, 4);
      sample(8, 0);
      sample(6, 6);
      chk("drop_dropped", 128'(dropped), 128'(1));
      chk("drop_mis", 128'(mis_count), 128'(2));
      chk("drop_keep_y1", 128'(rpt_y1), 128'(5));
      rpt_ready = 1'b1;
      cyc();
      chk("drop_valid_falls", 128'(rpt_valid), 128'(0));

      // Full buffer drains and reloads in the same cycle: no drop.
      rpt_ready = 1'b0;
      do_start();
      chk("restart_dropped", 128'(dropped), 128'(0));
      push_exp(16, 17, 1, 0);
      sample(16, 17);
      rpt_ready = 1'b1;
      push_exp(32, 34, 2, 1);
      sample(32, 34);
      chk("reload_valid", 128'(rpt_valid), 128'(1));
      chk("reload_dropped", 128'(dropped), 128'(0));
      chk("reload_y1", 128'(rpt_y1), 128'(32));
      cyc();
      chk("reload_drained", 128'(rpt_valid), 128'(0));

      // Saturation on the 4-bit counter copy.
      s_start = 1'b1; cyc(); s_start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         s_in_valid = 1'b1;
         s_y_1 = 8'(i);
         s_y_2 = 8'(i) ^ 8'h01;
         cyc();
      end
      s_in_valid = 1'b0;
      chk("sat_cmp", 128'(s_cmp_count), 128'(15));
      chk("sat_mis", 128'(s_mis_count), 128'(15));

      // Asynchronous reset with a report pending; samples ignored until start.
      rpt_ready = 1'b0;
      do_start();
      sample(7, 6);
      chk("prereset_valid", 128'(rpt_valid), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("areset_valid", 128'(rpt_valid), 128'(0));
      chk("areset_busy", 128'(busy), 128'(0));
      chk("areset_cmp", 128'(cmp_count), 128'(0));
      chk("areset_mis", 128'(mis_count), 128'(0));
      chk("areset_fail", 128'(fail), 128'(0));
      chk("areset_y1", 128'(rpt_y1), 128'(0));
      chk("areset_diff", 128'(rpt_diff), 128'(0));
      cyc();
      rst_n = 1'b1;
      rpt_ready = 1'b1;
      sample(1, 2);
      sample(3, 5);
      chk("idle_cmp", 128'(cmp_count), 128'(0));
      chk("idle_valid", 128'(rpt_valid), 128'(0));
      do_start();
      push_exp(12, 10, 6, 0);
      sample(12, 10);
      cyc(); cyc();
      chk("post_reset_cmp", 128'(cmp_count), 128'(1));

      chk("queue_empty", 128'(exp_q.size()), 128'(0));
      chk("report_count", 128'(reports), 128'(5));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/equiv_mismatch_monitor.md
EQUIV_MISMATCH_MONITOR -- requirements
Module: equiv_mismatch_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 91, width of each compared output word.
REQ-002 SHALL have parameter CNT_W, default 16, width of compare/mismatch counters and cycle stamp.
REQ-003 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  begin/restart a checking run.
REQ-006 SHALL have port stop  input  1  end current run.
REQ-007 SHALL have port in_valid  input  1  y_1/y_2 sample valid this cycle.
REQ-008 SHALL have port y_1  input  DATA_W  output of first design copy.
REQ-009 SHALL have port y_2  input  DATA_W  output of second design copy.
REQ-010 SHALL have port rpt_valid  output  1  mismatch report available.
REQ-011 SHALL have port rpt_ready  input  1  consumer accepts report.
REQ-012 SHALL have port rpt_y1, rpt_y2, rpt_diff  output  DATA_W each  captured y_1, y_2, y_1 XOR y_2.
REQ-013 SHALL have port rpt_stamp  output  CNT_W  compare index of reported mismatch.
REQ-014 SHALL have port cmp_count, mis_count  output  CNT_W each  compares and mismatches this run.
REQ-015 SHALL have port busy, fail, dropped  output  1 each  state RUN; mis_count nonzero; report lost.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL move IDLE->RUN or DONE->RUN on start; RUN->DONE on stop; start has priority over stop in same cycle; start in RUN restarts run.
REQ-018 SHALL, on entering RUN, clear cmp_count, mis_count, dropped, rpt_valid in same edge.
REQ-019 SHALL, in RUN with in_valid=1, increment cmp_count by 1; ignore samples in IDLE/DONE and in cycle start is asserted.
REQ-020 SHALL treat sample as mismatch when y_1 != y_2 across all DATA_W bits; increment mis_count.
REQ-021 SHALL saturate cmp_count and mis_count at all-ones, no wrap.
REQ-022 SHALL hold one-entry report buffer; on mismatch with buffer empty, or full and rpt_ready=1 same cycle, load rpt_y1/rpt_y2/rpt_diff/rpt_stamp and assert rpt_valid next cycle (latency 1).
REQ-023 SHALL, on mismatch with buffer full and rpt_ready=0, keep existing report, count mismatch, set dropped sticky.
REQ-024 SHALL keep rpt_* stable while rpt_valid=1 and rpt_ready=0; clear rpt_valid on rpt_valid&&rpt_ready unless reloaded same edge.
REQ-025 SHALL keep report handshake active in DONE so pending report drains; counters frozen in DONE.
REQ-026 SHALL drive fail = (mis_count != 0), busy = (state==RUN), combinationally from registers.

Reset
REQ-027 SHALL on rst_n=0 immediately force state IDLE, all counters 0, rpt_valid 0, rpt_y1/rpt_y2/rpt_diff/rpt_stamp 0, dropped 0, fail 0, busy 0.
REQ-028 SHALL, on reset mid-run, discard pending report without handshake.

Configuration
REQ-029 SHALL, with EQUIV_MON_STAMP_EN defined, set rpt_stamp = cmp_count value before increment (0-based index) of captured mismatch.
REQ-030 SHALL, without EQUIV_MON_STAMP_EN, omit stamp register and tie rpt_stamp to 0; all else unchanged.

Verification
REQ-031 SHALL cover: start, 10 equal samples, stop -> cmp_count=10, mis_count=0, fail=0, rpt_valid never 1, state DONE.
REQ-032 SHALL cover: start, samples 0..4, sample 3 has y_1=1, y_2=3, rpt_ready=1 -> rpt_valid one cycle after sample 3, rpt_diff=2, rpt_stamp=3 (0 if macro off), mis_count=1.
REQ-033 SHALL cover: rpt_ready=0, mismatches at samples 1 and 2 -> report keeps sample 1 data, dropped=1, mis_count=2; raise rpt_ready -> rpt_valid falls next cycle.
REQ-034 SHALL cover: buffer full, rpt_ready=1 and new mismatch same cycle -> rpt_valid stays 1 with new sample data, dropped=0.
REQ-035 SHALL cover: CNT_W=4, 20 mismatching samples -> cmp_count=15, mis_count=15, no wrap.
REQ-036 SHALL cover: rst_n low mid-run with rpt_valid=1 -> all outputs 0, IDLE same cycle; samples ignored until start.
